// File: rtl/ro_edge_sampler.sv
// ro_edge_sampler
//
// Synchronises a free-running ring-oscillator tap into clk and counts its
// rising edges over back-to-back windows of WINDOW cycles. Each window's count
// goes into a first-word-fall-through FIFO read out over a valid/ready stream.
// A capture lasts NUM_SAMPLES windows and is gated by the level of en.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for en; counters parked
// MEASURE | counting edges, pushing one sample per window
// DONE    | capture complete; waiting for en to drop
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   en           capture enable (level)
//   ro_in        ring-oscillator tap, asynchronous to clk
//   sample_data  FIFO head sample, 0 when empty
//   sample_valid FIFO not empty
//   sample_ready consumer accepts the head sample
//   busy         high in MEASURE
//   done         high in DONE
//   overflow     sticky: a sample was dropped on a full FIFO
module ro_edge_sampler #(
  parameter int COUNT_WIDTH = 16,
  parameter int WINDOW      = 100,
  parameter int NUM_SAMPLES = 256,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   ro_in,
  output logic [COUNT_WIDTH-1:0] sample_data,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);

  localparam int WIN_W  = $clog2(WINDOW);
  localparam int IDX_W  = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
  localparam int ADDR_W = $clog2(FIFO_DEPTH);

  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_SAMPLES - 1);
  localparam logic [ADDR_W:0]   FIFO_FULL_CNT = (ADDR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   sync1_q, sync1_d;
  logic                   sync2_q, sync2_d;
  logic                   sync3_q, sync3_d;
  logic [WIN_W-1:0]       win_cnt_q, win_cnt_d;
  logic [COUNT_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   overflow_q, overflow_d;
  logic [COUNT_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [COUNT_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]        fifo_cnt_q, fifo_cnt_d;

  logic                   rise;
  logic [COUNT_WIDTH-1:0] edge_sum;
  logic                   push;
  logic                   push_ok;
  logic                   pop;
  logic                   fifo_full;

  assign sample_valid = (fifo_cnt_q != '0);
  assign sample_data  = sample_valid ? mem_q[rd_ptr_q] : '0;
  assign busy         = (state_q == S_MEASURE);
  assign done         = (state_q == S_DONE);
  assign overflow     = overflow_q;

  always_comb begin
    state_d    = state_q;
    sync1_d    = ro_in;
    sync2_d    = sync1_q;
    sync3_d    = sync2_q;
    win_cnt_d  = win_cnt_q;
    edge_cnt_d = edge_cnt_q;
    idx_d      = idx_q;
    overflow_d = overflow_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    push       = 1'b0;

    rise = sync2_q & ~sync3_q;
    // Saturating count including this cycle's edge, so the window's last
    // cycle still contributes to the pushed sample.
    edge_sum = (rise && (edge_cnt_q != '1)) ? edge_cnt_q + 1'b1 : edge_cnt_q;

    pop       = sample_valid & sample_ready;
    fifo_full = (fifo_cnt_q == FIFO_FULL_CNT);

    case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d    = S_MEASURE;
          win_cnt_d  = WIN_LAST;
          edge_cnt_d = '0;
          idx_d      = '0;
          overflow_d = 1'b0;
        end
      end
      S_MEASURE: begin
        if (!en) begin
          // Abort wins over a coincident window end; partial window is lost.
          state_d = S_IDLE;
        end else if (win_cnt_q == '0) begin
          push       = 1'b1;
          edge_cnt_d = '0;
          win_cnt_d  = WIN_LAST;
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          win_cnt_d  = win_cnt_q - 1'b1;
          edge_cnt_d = edge_sum;
        end
      end
      S_DONE: begin
        if (!en) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_ok = push && (!fifo_full || pop);
    if (push && !push_ok) begin
      overflow_d = 1'b1;
    end
    if (push_ok) begin
      mem_d[wr_ptr_q] = edge_sum;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      win_cnt_q  <= '0;
      edge_cnt_q <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      sync3_q    <= sync3_d;
      win_cnt_q  <= win_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      mem_q      <= mem_d;
    end
  end

endmodule

// File: tb/tb_ro_edge_sampler.sv
// Testbench for ro_edge_sampler: a main instance checked every cycle against
// a window/queue-level model, plus a narrow-count instance for saturation.
module tb_ro_edge_sampler;

  localparam int CW   = 8;
  localparam int WIN  = 20;
  localparam int NS   = 10;
  localparam int FD   = 8;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          en;
  logic          ro_in = 1'b0;
  logic [CW-1:0] sample_data;
  logic          sample_valid;
  logic          sample_ready;
  logic          busy;
  logic          done;
  logic          overflow;

  logic          en2;
  logic          ro2 = 1'b0;
  logic [3:0]    data2;
  logic          valid2;
  logic          ready2;
  logic          busy2;
  logic          done2;
  logic          ovf2;

  ro_edge_sampler #(.COUNT_WIDTH(CW), .WINDOW(WIN), .NUM_SAMPLES(NS), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .en(en), .ro_in(ro_in),
    .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .busy(busy), .done(done), .overflow(overflow)
  );

  ro_edge_sampler #(.COUNT_WIDTH(4), .WINDOW(40), .NUM_SAMPLES(2), .FIFO_DEPTH(4)) dut_sat (
    .clk(clk), .rst(rst), .en(en2), .ro_in(ro2),
    .sample_data(data2), .sample_valid(valid2), .sample_ready(ready2),
    .busy(busy2), .done(done2), .overflow(ovf2)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ro_in generator: period 0 holds ro_level, otherwise a square wave.
  int   ro_period = 0;
  logic ro_level  = 1'b0;
  int   ro_phase  = 0;
  always @(negedge clk) begin
    if (ro_period == 0) begin
      ro_in = ro_level;
    end else begin
      ro_in    = (ro_phase < ro_period / 2);
      ro_phase = (ro_phase + 1) % ro_period;
    end
    ro2 = ~ro2;
  end

  // Model: 0 idle, 1 measuring, 2 done.
  int   m_mode = 0;
  int   m_pos = 0;
  int   m_acc = 0;
  int   m_nsamp = 0;
  bit   m_ovf = 0;
  int   m_q[$];
  bit   h1 = 0, h2 = 0, h3 = 0;
  int   got[$];
  int   busy_cycles = 0;
  bit   m_rise;
  bit   m_pop;

  always @(posedge clk) begin
    if (!rst && sample_valid && sample_ready) got.push_back(int'(sample_data));
    // An edge is counted three capture slots after ro_in is sampled.
    m_rise = h2 & ~h3;
    if (rst) begin
      m_mode = 0; m_pos = 0; m_acc = 0; m_nsamp = 0; m_ovf = 0;
      m_q.delete();
      h1 = 0; h2 = 0; h3 = 0;
    end else begin
      h3 = h2; h2 = h1; h1 = ro_in;
      m_pop = (m_q.size() > 0) && sample_ready;
      if (m_pop) void'(m_q.pop_front());
      case (m_mode)
        0: if (en) begin
          m_mode = 1; m_pos = 0; m_acc = 0; m_nsamp = 0; m_ovf = 0;
        end
        1: if (!en) begin
          m_mode = 0;
        end else begin
          m_acc = m_acc + int'(m_rise);
          if (m_acc > MAXC) m_acc = MAXC;
          m_pos++;
          if (m_pos == WIN) begin
            if (m_q.size() < FD) m_q.push_back(m_acc);
            else m_ovf = 1;
            m_acc = 0;
            m_pos = 0;
            m_nsamp++;
            if (m_nsamp == NS) m_mode = 2;
          end
        end
        default: if (!en) m_mode = 0;
      endcase
    end
    #1;
    check("busy", int'(busy), int'(m_mode == 1));
    check("done", int'(done), int'(m_mode == 2));
    check("overflow", int'(overflow), int'(m_ovf));
    check("sample_valid", int'(sample_valid), int'(m_q.size() > 0));
    check("sample_data", int'(sample_data), (m_q.size() > 0) ? m_q[0] : 0);
    if (busy) busy_cycles++;
  end

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_reached", int'(done), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; en = 1'b0; sample_ready = 1'b0; en2 = 1'b0; ready2 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", int'(sample_valid), 0);
    check("rst_data", int'(sample_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_ovf", int'(overflow), 0);
    rst = 1'b0;
    @(negedge clk);

    // Nominal capture: period 4 -> 5 edges per 20-cycle window.
    ro_period = 4; sample_ready = 1'b1;
    got.delete(); busy_cycles = 0;
    en = 1'b1;
    wait_done(NS * WIN + 20);
    check("nom_busy_cycles", busy_cycles, NS * WIN);
    en = 1'b0;
    @(negedge clk);
    check("nom_done_fall", int'(done), 0);
    check("nom_count", got.size(), NS);
    if (got.size() == NS) begin
      check("nom_first_in_range", int'(got[0] >= 4 && got[0] <= 6), 1);
      for (int i = 1; i < NS; i++) check("nom_sample", got[i], 5);
    end

    // Backpressure: 8 fit, 9th window overflows.
    sample_ready = 1'b0; got.delete();
    @(negedge clk);
    en = 1'b1;
    repeat (9 * WIN) @(negedge clk);
    check("bp_ovf_before", int'(overflow), 0);
    @(negedge clk);
    check("bp_ovf_after9", int'(overflow), 1);
    wait_done(2 * WIN + 10);
    en = 1'b0; sample_ready = 1'b1;
    repeat (FD + 3) @(negedge clk);
    check("bp_drained", got.size(), FD);
    check("bp_empty", int'(sample_valid), 0);
    check("bp_ovf_sticky", int'(overflow), 1);
    if (got.size() == FD) for (int i = 1; i < FD; i++) check("bp_sample", got[i], 5);

    // Abort mid-way through the second window, then restart.
    got.delete();
    en = 1'b1;
    @(negedge clk);
    check("ab_ovf_cleared", int'(overflow), 0);
    repeat (29) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("ab_busy_low", int'(busy), 0);
    repeat (5) @(negedge clk);
    check("ab_count", got.size(), 1);
    got.delete();
    en = 1'b1;
    repeat (2 * WIN + 2) @(negedge clk);
    check("ab_restart_count", got.size(), 2);
    check("ab_restart_busy", int'(busy), 1);
    en = 1'b0;
    repeat (3) @(negedge clk);

    // No edges: ro_in held high.
    ro_period = 0; ro_level = 1'b1;
    repeat (5) @(negedge clk);
    got.delete();
    en = 1'b1;
    wait_done(NS * WIN + 20);
    en = 1'b0;
    repeat (2) @(negedge clk);
    check("ne_count", got.size(), NS);
    foreach (got[i]) check("ne_sample", got[i], 0);

    // Reset during a capture with a non-empty FIFO.
    ro_period = 4; sample_ready = 1'b0;
    @(negedge clk);
    en = 1'b1;
    repeat (50) @(negedge clk);
    check("rm_valid_before", int'(sample_valid), 1);
    rst = 1'b1; en = 1'b0;
    repeat (2) @(negedge clk);
    check("rm_valid", int'(sample_valid), 0);
    check("rm_data", int'(sample_data), 0);
    check("rm_busy", int'(busy), 0);
    check("rm_done", int'(done), 0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("rm_no_samples", int'(sample_valid), 0);

    // Saturation: 20 edges per window on a 4-bit counter -> 15.
    en2 = 1'b1;
    for (int n = 0; n < 100 && !done2; n++) @(negedge clk);
    check("sat_done", int'(done2), 1);
    check("sat_valid", int'(valid2), 1);
    check("sat_s0", int'(data2), 15);
    check("sat_ovf", int'(ovf2), 0);
    ready2 = 1'b1;
    @(negedge clk);
    check("sat_s1", int'(data2), 15);
    @(negedge clk);
    check("sat_empty", int'(valid2), 0);
    ready2 = 1'b0; en2 = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ro_edge_sampler.md
# ro_edge_sampler

Measurement-side counterpart to the switching aggressor in the ring-oscillator SPA design. The block synchronises a free-running ring-oscillator tap into the system clock domain and counts its rising edges over back-to-back fixed windows. Each window's count is one sample of the local supply droop, delivered through a small FIFO on a valid/ready stream. A capture runs for a programmed number of windows, gated by `en`, so the traces line up with the aggressor's switch/idle periods.

## Interface
Parameters:
- `COUNT_WIDTH`, 16: width of one sample (edge count per window).
- `WINDOW`, 100: clock cycles per sample window; must be ≥ 2.
- `NUM_SAMPLES`, 256: windows per capture; must be ≥ 1.
- `FIFO_DEPTH`, 8: sample FIFO entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  system clock; one clock domain for the whole block.
- `rst`  in  1  reset; synchronous and active-high.
- `en`  in  1  capture enable, level-sensitive.
- `ro_in`  in  1  ring-oscillator tap, asynchronous to `clk`.
- `sample_data`  out  COUNT_WIDTH  FIFO head sample; 0 when the FIFO is empty.
- `sample_valid`  out  1  FIFO not empty.
- `sample_ready`  in  1  consumer accepts the head sample.
- `busy`  out  1  high in MEASURE.
- `done`  out  1  high in DONE.
- `overflow`  out  1  sticky: a sample was dropped because the FIFO was full.

## Operation
- **Input path:** `ro_in` passes through a 2-flop synchroniser, then an edge register. A rising edge is `sync2 & ~sync3`. Falling edges are not counted.
- **State machine:** IDLE, MEASURE, DONE. Any illegal state encoding goes to IDLE.
  - **IDLE:** when `en`=1, go to MEASURE. On that transition: window counter = WINDOW-1, edge counter = 0, sample index = 0, `overflow` cleared.
  - **MEASURE:** every cycle, the edge counter increments on a detected rising edge and saturates at all-ones (no wrap). The window counter decrements each cycle.
  - **MEASURE, window counter = 0:** push the count into the FIFO, including any edge detected in this same cycle. Then set edge counter = 0 and window counter = WINDOW-1. If sample index = NUM_SAMPLES-1, go to DONE; otherwise increment the sample index.
  - **MEASURE, `en`=0:** go to IDLE at once and discard the partial window (no push). `en`=0 takes priority over a window end in the same cycle.
  - **DONE:** hold until `en`=0, then go to IDLE. A new capture needs `en` to drop and rise again.
- **FIFO:** first-word-fall-through. A pop happens when `sample_valid & sample_ready`.
  - A push into a full FIFO with a pop in the same cycle is accepted.
  - A push into a full FIFO with no pop is dropped and sets `overflow`. The dropped sample still counts toward NUM_SAMPLES.
  - The FIFO is not flushed by the IDLE→MEASURE transition; only `rst` empties it.
- **Reset mid-capture:** the state returns to IDLE, all counters clear, the FIFO empties, and the partial window is lost.

## Timing
- **Reset values:** `sample_data`=0, `sample_valid`=0, `busy`=0, `done`=0, `overflow`=0. State is IDLE, FIFO empty, all counters 0.
- **Edge latency:** a `ro_in` rising edge is counted in the 3rd `clk` cycle after it is captured by the first synchroniser flop.
- **Capture timing:** with `en` seen in IDLE at cycle t, window k (k = 0…NUM_SAMPLES-1) covers cycles t+1+k·WINDOW through t+(k+1)·WINDOW. Windows are contiguous with no dead cycles.
- **Sample latency:** a window's sample is visible on `sample_valid`/`sample_data` the cycle after its last cycle, if the FIFO was empty.
- **DONE timing:** `busy` falls and `done` rises the cycle after the last window ends.
- **Edge-rate limit:** at most one edge is detected every 2 cycles, so at most ⌈WINDOW/2⌉ edges per window.

## Test plan
1. **Reset:** assert `rst` for 2 cycles during an active capture with a non-empty FIFO → all outputs 0, `sample_valid`=0 on the next cycle, no further samples.
2. **Nominal capture:** WINDOW=100, NUM_SAMPLES=4, `ro_in` period 4 clk, `sample_ready`=1, `en` held → four samples of 25 each (±1 on the first), `busy` high for 400 cycles, then `done`=1; `done` falls 1 cycle after `en`=0.
3. **Saturation:** COUNT_WIDTH=4, WINDOW=100, `ro_in` period 2 clk → every sample = 15, no wrap to a small value.
4. **Backpressure:** FIFO_DEPTH=8, NUM_SAMPLES=10, `sample_ready`=0 until `done` → `overflow`=1 after the 9th window; draining yields exactly 8 samples, then `sample_valid`=0.
5. **Abort and restart:** drop `en` at cycle 150 of a WINDOW=100 capture → exactly 1 sample, `busy`=0 next cycle. Re-raise `en` → `overflow` cleared, a fresh first window starts.
6. **No edges:** `ro_in` held at 1 → all samples = 0.
